// File: rtl/uart_error_tracker.sv
// rtl/uart_error_tracker.sv - UART receive error status, break/timeout detection and event counters (optional counters: UART_ERR_COUNTERS_EN)
module uart_error_tracker #(
    parameter int CNT_WIDTH = 8,
    parameter int DIV_WIDTH = 16,
    parameter int PER_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_error,
    input  logic                 parity_error,
    input  logic                 overrun_error,
    input  logic                 frame_active,
    input  logic                 rx_filtered,
    input  logic [DIV_WIDTH-1:0] bit_div,
    input  logic [PER_WIDTH-1:0] break_bits,
    input  logic [PER_WIDTH-1:0] timeout_bits,
    input  logic [4:0]           err_clear,
    input  logic [4:0]           irq_mask,
    input  logic                 cnt_clear,
    output logic [4:0]           status,
    output logic [4:0]           first_err,
    output logic                 error_any,
    output logic                 irq,
    output logic [CNT_WIDTH-1:0] cnt_frame,
    output logic [CNT_WIDTH-1:0] cnt_parity,
    output logic [CNT_WIDTH-1:0] cnt_overrun,
    output logic [CNT_WIDTH-1:0] cnt_break
);

    typedef enum logic [1:0] {
        LINE_IDLE  = 2'd0,
        LINE_LOW   = 2'd1,
        LINE_BREAK = 2'd2
    } line_state_e;

    // Registered state
    logic [4:0]           status_q, status_d;
    logic [4:0]           first_err_q, first_err_d;
    logic                 irq_q, irq_d;
    logic                 rx_q, rx_d;
    logic                 fa_q, fa_d;
    logic [DIV_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
    logic [PER_WIDTH-1:0] low_cnt_q, low_cnt_d;
    logic [PER_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
    logic                 armed_q, armed_d;
    line_state_e          state_q, state_d;

    // Combinational helpers
    logic                 rx_edge;
    logic                 tick;
    logic [DIV_WIDTH-1:0] div_eff;
    logic [DIV_WIDTH-1:0] tick_base;
    logic [DIV_WIDTH-1:0] tick_inc;
    logic [PER_WIDTH-1:0] low_inc;
    logic [PER_WIDTH-1:0] idle_inc;
    logic                 break_entry;
    logic                 timeout_hit;
    logic                 frame_ok;
    logic [4:0]           set_bits;

    // Bit-period tick: the edge cycle counts as the first cycle of a new period
    always_comb begin
        rx_d       = rx_filtered;
        rx_edge    = (rx_filtered != rx_q);
        div_eff    = (bit_div == '0) ? DIV_WIDTH'(1) : bit_div;
        tick_base  = rx_edge ? '0 : tick_cnt_q;
        tick_inc   = tick_base + DIV_WIDTH'(1);
        tick       = (tick_inc >= div_eff);
        tick_cnt_d = tick ? '0 : tick_inc;
    end

    // Line FSM next state: counts low bit periods and flags a break once per low run
    always_comb begin
        state_d     = state_q;
        low_cnt_d   = low_cnt_q;
        break_entry = 1'b0;
        low_inc     = (low_cnt_q == '1) ? low_cnt_q : low_cnt_q + PER_WIDTH'(1);
        case (state_q)
            LINE_IDLE: begin
                low_cnt_d = '0;
                if (!rx_filtered) begin
                    state_d = LINE_LOW;
                end
            end
            LINE_LOW: begin
                if (rx_filtered) begin
                    state_d   = LINE_IDLE;
                    low_cnt_d = '0;
                end else if (tick) begin
                    low_cnt_d = low_inc;
                    if ((break_bits != '0) && (low_inc >= break_bits)) begin
                        state_d     = LINE_BREAK;
                        break_entry = 1'b1;
                        low_cnt_d   = '0;
                    end
                end
            end
            LINE_BREAK: begin
                low_cnt_d = '0;
                if (rx_filtered) begin
                    state_d = LINE_IDLE;
                end
            end
            default: begin
                state_d   = LINE_IDLE;
                low_cnt_d = '0;
            end
        endcase
    end

    // Idle timeout: armed at end of frame, fires once per idle gap
    always_comb begin
        fa_d        = frame_active;
        armed_d     = armed_q;
        idle_cnt_d  = idle_cnt_q;
        timeout_hit = 1'b0;
        idle_inc    = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + PER_WIDTH'(1);
        if (rx_edge || frame_active) begin
            idle_cnt_d = '0;
        end else if (armed_q && rx_filtered && tick) begin
            idle_cnt_d = idle_inc;
            if ((timeout_bits != '0) && (idle_inc >= timeout_bits)) begin
                timeout_hit = 1'b1;
                armed_d     = 1'b0;
                idle_cnt_d  = '0;
            end
        end
        if (fa_q && !frame_active) begin
            armed_d = 1'b1;
        end
    end

    // Sticky status, first-error capture and registered interrupt
    always_comb begin
        frame_ok = frame_error && (state_q != LINE_BREAK) && !break_entry;
        set_bits = {timeout_hit, break_entry, overrun_error, parity_error, frame_ok};
        status_d = (status_q & ~err_clear) | set_bits;
        if (break_entry) begin
            // A break is what really happened; the stop-bit error it caused is dropped
            status_d[0] = 1'b0;
        end
        if (status_d == 5'd0) begin
            first_err_d = 5'd0;
        end else if (status_q == 5'd0) begin
            first_err_d = status_d & (~status_d + 5'd1);
        end else begin
            first_err_d = first_err_q;
        end
        irq_d = |(status_q & ~irq_mask);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q    <= 5'd0;
            first_err_q <= 5'd0;
            irq_q       <= 1'b0;
            rx_q        <= 1'b1;
            fa_q        <= 1'b0;
            tick_cnt_q  <= '0;
            low_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            armed_q     <= 1'b0;
            state_q     <= LINE_IDLE;
        end else begin
            status_q    <= status_d;
            first_err_q <= first_err_d;
            irq_q       <= irq_d;
            rx_q        <= rx_d;
            fa_q        <= fa_d;
            tick_cnt_q  <= tick_cnt_d;
            low_cnt_q   <= low_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
        end
    end

    assign status    = status_q;
    assign first_err = first_err_q;
    assign error_any = |status_q;
    assign irq       = irq_q;

`ifdef UART_ERR_COUNTERS_EN
    logic [CNT_WIDTH-1:0] cnt_frame_q, cnt_frame_d;
    logic [CNT_WIDTH-1:0] cnt_parity_q, cnt_parity_d;
    logic [CNT_WIDTH-1:0] cnt_overrun_q, cnt_overrun_d;
    logic [CNT_WIDTH-1:0] cnt_break_q, cnt_break_d;

    function automatic logic [CNT_WIDTH-1:0] cnt_next(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 inc,
        input logic                 clr
    );
        logic [CNT_WIDTH-1:0] nxt;
        if (clr) begin
            nxt = inc ? CNT_WIDTH'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            nxt = cnt + CNT_WIDTH'(1);
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    // Saturating event counters; a clear coincident with an event leaves one count
    always_comb begin
        cnt_frame_d   = cnt_next(cnt_frame_q, frame_ok, cnt_clear);
        cnt_parity_d  = cnt_next(cnt_parity_q, parity_error, cnt_clear);
        cnt_overrun_d = cnt_next(cnt_overrun_q, overrun_error, cnt_clear);
        cnt_break_d   = cnt_next(cnt_break_q, break_entry, cnt_clear);
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_frame_q   <= '0;
            cnt_parity_q  <= '0;
            cnt_overrun_q <= '0;
            cnt_break_q   <= '0;
        end else begin
            cnt_frame_q   <= cnt_frame_d;
            cnt_parity_q  <= cnt_parity_d;
            cnt_overrun_q <= cnt_overrun_d;
            cnt_break_q   <= cnt_break_d;
        end
    end

    assign cnt_frame   = cnt_frame_q;
    assign cnt_parity  = cnt_parity_q;
    assign cnt_overrun = cnt_overrun_q;
    assign cnt_break   = cnt_break_q;
`else
    logic unused_cnt_clear;
    assign unused_cnt_clear = cnt_clear;
    assign cnt_frame        = '0;
    assign cnt_parity       = '0;
    assign cnt_overrun      = '0;
    assign cnt_break        = '0;
`endif

endmodule

// File: tb/tb_uart_error_tracker.sv
// tb/tb_uart_error_tracker.sv - self-checking bench for uart_error_tracker
module tb_uart_error_tracker;

`ifdef UART_ERR_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int CW      = 4;
    localparam int CNT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_error = 1'b0;
    logic        parity_error = 1'b0;
    logic        overrun_error = 1'b0;
    logic        frame_active = 1'b0;
    logic        rx_filtered = 1'b1;
    logic [15:0] bit_div = 16'd16;
    logic [7:0]  break_bits = 8'd11;
    logic [7:0]  timeout_bits = 8'd3;
    logic [4:0]  err_clear = 5'd0;
    logic [4:0]  irq_mask = 5'd0;
    logic        cnt_clear = 1'b0;
    logic [4:0]  status;
    logic [4:0]  first_err;
    logic        error_any;
    logic        irq;
    logic [CW-1:0] cnt_frame, cnt_parity, cnt_overrun, cnt_break;

    int n_checks = 0;
    int n_errors = 0;

    uart_error_tracker #(.CNT_WIDTH(CW), .DIV_WIDTH(16), .PER_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .frame_error(frame_error), .parity_error(parity_error), .overrun_error(overrun_error),
        .frame_active(frame_active), .rx_filtered(rx_filtered),
        .bit_div(bit_div), .break_bits(break_bits), .timeout_bits(timeout_bits),
        .err_clear(err_clear), .irq_mask(irq_mask), .cnt_clear(cnt_clear),
        .status(status), .first_err(first_err), .error_any(error_any), .irq(irq),
        .cnt_frame(cnt_frame), .cnt_parity(cnt_parity), .cnt_overrun(cnt_overrun), .cnt_break(cnt_break)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks run lengths of the line level and counts ticks
    // as multiples of the bit period within each run.
    logic [4:0] m_status, m_first, m_nxt;
    logic       m_irq;
    int         m_cnt [4];
    logic       m_rx_prev, m_fa_prev, m_broke, m_armed;
    int         m_run, m_low_ticks, m_idle, m_div;
    logic       m_edge, m_tick, m_brk, m_tmo, m_frame_ok;
    logic [3:0] m_inc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_status = 0; m_first = 0; m_irq = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_rx_prev = 1; m_fa_prev = 0; m_broke = 0; m_armed = 0;
            m_run = 0; m_low_ticks = 0; m_idle = 0;
        end else begin
            m_edge = (rx_filtered != m_rx_prev);
            m_run  = m_edge ? 1 : m_run + 1;
            m_div  = (bit_div == 0) ? 1 : int'(bit_div);
            m_tick = ((m_run % m_div) == 0);
            m_brk  = 0;
            if (rx_filtered || m_edge) m_low_ticks = 0;
            else if (!m_broke && m_tick) begin
                m_low_ticks++;
                if (break_bits != 0 && m_low_ticks >= int'(break_bits)) m_brk = 1;
            end
            m_frame_ok = frame_error && !m_broke && !m_brk;
            if (rx_filtered) m_broke = 0;
            else if (m_brk) m_broke = 1;

            m_tmo = 0;
            if (m_edge || frame_active) m_idle = 0;
            else if (m_armed && rx_filtered && m_tick) begin
                m_idle++;
                if (timeout_bits != 0 && m_idle >= int'(timeout_bits)) begin
                    m_tmo = 1; m_armed = 0; m_idle = 0;
                end
            end
            if (m_fa_prev && !frame_active) m_armed = 1;

            m_nxt = (m_status & ~err_clear) | {m_tmo, m_brk, overrun_error, parity_error, m_frame_ok};
            if (m_brk) m_nxt[0] = 0;
            m_irq = |(m_status & ~irq_mask);
            if (m_nxt == 0) m_first = 0;
            else if (m_status == 0) begin
                m_first = 0;
                for (int i = 0; i < 5; i++) if (m_nxt[i] && m_first == 0) m_first[i] = 1'b1;
            end
            m_status = m_nxt;

            m_inc = {m_brk, overrun_error, parity_error, m_frame_ok};
            for (int i = 0; i < 4; i++) begin
                if (cnt_clear) m_cnt[i] = m_inc[i] ? 1 : 0;
                else if (m_inc[i] && m_cnt[i] < CNT_MAX) m_cnt[i]++;
            end
            m_rx_prev = rx_filtered;
            m_fa_prev = frame_active;
        end
    end

    function automatic int exp_cnt(input int i);
        return CNT_EN ? m_cnt[i] : 0;
    endfunction

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("status", status, m_status);
        check("first_err", first_err, m_first);
        check("error_any", error_any, |m_status);
        check("irq", irq, m_irq);
        check("cnt_frame", cnt_frame, exp_cnt(0));
        check("cnt_parity", cnt_parity, exp_cnt(1));
        check("cnt_overrun", cnt_overrun, exp_cnt(2));
        check("cnt_break", cnt_break, exp_cnt(3));
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_all();
        @(negedge clk); err_clear = 5'h1f;
        @(negedge clk); err_clear = 5'h00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        wait_n(3);
        check("rst_status", status, 5'd0);
        check("rst_irq", irq, 0);
        check("rst_first", first_err, 5'd0);
        rst_n = 1'b1;

        // parity pulse at cycle 10
        wait_n(9); parity_error = 1'b1;
        wait_n(1); parity_error = 1'b0;
        check("par_status", status, 5'b00010);
        check("par_irq_lat", irq, 0);
        wait_n(1);
        check("par_irq", irq, 1);
        check("par_first", first_err, 5'b00010);
        check("par_cnt", cnt_parity, CNT_EN ? 1 : 0);
        err_clear = 5'b00010;
        wait_n(1); err_clear = 5'd0;
        check("par_clr", status, 5'd0);
        check("par_first_clr", first_err, 5'd0);

        // simultaneous frame + overrun, then clear with a new overrun
        wait_n(1); frame_error = 1'b1; overrun_error = 1'b1;
        wait_n(1); frame_error = 1'b0; overrun_error = 1'b0;
        check("dual_status", status, 5'b00101);
        check("dual_first", first_err, 5'b00001);
        err_clear = 5'b00101; overrun_error = 1'b1;
        wait_n(1); err_clear = 5'd0; overrun_error = 1'b0;
        check("setclr_status", status, 5'b00100);
        check("setclr_first", first_err, 5'b00001);
        clear_all();

        // break: 200 low cycles, frame pulse before and during the break
        wait_n(1); rx_filtered = 1'b0;
        wait_n(100); frame_error = 1'b1;
        wait_n(1); frame_error = 1'b0;
        wait_n(74);
        check("brk_pre", status, 5'b00001);
        wait_n(1);
        check("brk_set", status, 5'b01000);
        wait_n(14); frame_error = 1'b1;
        wait_n(1); frame_error = 1'b0;
        wait_n(9); rx_filtered = 1'b1;
        wait_n(2);
        check("brk_hold", status, 5'b01000);
        check("brk_cnt", cnt_break, CNT_EN ? 1 : 0);
        check("brk_frame_cnt", cnt_frame, CNT_EN ? 2 : 0);
        clear_all();

        // idle timeout after end of frame
        wait_n(1); frame_active = 1'b1; rx_filtered = 1'b0;
        wait_n(20); frame_active = 1'b0; rx_filtered = 1'b1;
        wait_n(47);
        check("tmo_early", status[4], 0);
        wait_n(1);
        check("tmo_set", status[4], 1);
        err_clear = 5'b10000;
        wait_n(1); err_clear = 5'd0;
        wait_n(500);
        check("tmo_once", status, 5'd0);

        // break threshold lowered mid-count
        clear_all();
        wait_n(1); rx_filtered = 1'b0;
        wait_n(40); break_bits = 8'd3;
        wait_n(7);
        check("bb_chg_pre", status[3], 0);
        wait_n(1);
        check("bb_chg_set", status[3], 1);
        wait_n(12); rx_filtered = 1'b1; break_bits = 8'd11;
        wait_n(2);
        clear_all();

        // masked interrupt
        wait_n(1); irq_mask = 5'b00010; parity_error = 1'b1;
        wait_n(1); parity_error = 1'b0;
        wait_n(3);
        check("mask_irq", irq, 0);
        check("mask_status", status, 5'b00010);
        irq_mask = 5'd0;
        wait_n(1);
        check("unmask_irq", irq, 1);
        clear_all();

        // counter saturation and clear-with-increment
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); frame_error = 1'b1;
            @(negedge clk); frame_error = 1'b0;
        end
        check("sat_frame", cnt_frame, CNT_EN ? 15 : 0);
        frame_error = 1'b1; cnt_clear = 1'b1;
        wait_n(1); frame_error = 1'b0; cnt_clear = 1'b0;
        check("clr_frame", cnt_frame, CNT_EN ? 1 : 0);
        check("clr_parity", cnt_parity, 0);
        clear_all();

        // timeout disabled
        timeout_bits = 8'd0;
        wait_n(1); frame_active = 1'b1;
        wait_n(1); frame_active = 1'b0;
        wait_n(100);
        check("tmo_off", status[4], 0);

        // reset asserted mid-break
        clear_all();
        wait_n(1); rx_filtered = 1'b0; timeout_bits = 8'd3;
        wait_n(180); parity_error = 1'b1;
        wait_n(1); parity_error = 1'b0;
        wait_n(9);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_status", status, 5'd0);
        check("rst_mid_irq", irq, 0);
        check("rst_mid_first", first_err, 5'd0);
        check("rst_mid_any", error_any, 0);
        check("rst_mid_cnt", cnt_break, 0);
        rx_filtered = 1'b1;
        wait_n(3); rst_n = 1'b1;
        wait_n(300);
        check("post_rst_status", status, 5'd0);
        check("post_rst_irq", irq, 0);

        wait_n(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
